// File: rtl/wb_arbiter_ctrl.sv
// Register-file write-back sequencer: arbitrates N_SRC sources onto the MemToReg mux and write port.
// Define WB_FAST_EN to drop the mux-settle SELECT cycle (1 write per cycle).
module wb_arbiter_ctrl #(
  parameter int N_SRC    = 9,
  parameter int EXC_SRC  = 5,
  parameter int EXC_DEST = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   req,
  input  logic [5*N_SRC-1:0] dest_flat,
  output logic [N_SRC-1:0]   ack,
  output logic [3:0]         mem_to_reg,
  output logic               reg_write,
  output logic [4:0]         write_reg,
  output logic               busy
);

  localparam int SEL_W = 4;

  typedef enum logic [1:0] {IDLE, SELECT, WRITE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [4:0]         wreg_q, wreg_d;
  logic               regw_q, regw_d;
  logic [N_SRC-1:0]   ack_q, ack_d;

  logic [N_SRC-1:0]   masked;
  logic               win_valid;
  logic [SEL_W-1:0]   win_idx;
  logic [4:0]         win_dest;
  logic               take;

  function automatic logic [SEL_W-1:0] rr_after(input logic [SEL_W-1:0] g);
    int n;
    n = int'(g) + 1;
    if (n >= N_SRC) n = 0;
    if (n == EXC_SRC) n = n + 1;
    if (n >= N_SRC) n = 0;
    return SEL_W'(n);
  endfunction

  // The source being acked in WRITE still holds req this cycle, so it must not win again.
  always_comb begin
    masked = req;
    if (state_q == WRITE) masked[sel_q] = 1'b0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (idx != EXC_SRC && masked[idx]) begin
        win_valid = 1'b1;
        win_idx   = SEL_W'(idx);
      end
    end
    if (masked[EXC_SRC]) begin
      win_valid = 1'b1;
      win_idx   = SEL_W'(EXC_SRC);
    end
    win_dest = (win_idx == SEL_W'(EXC_SRC)) ? 5'(EXC_DEST) : dest_flat[5*win_idx +: 5];
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    wreg_d  = wreg_q;
    regw_d  = 1'b0;
    ack_d   = '0;
    take    = 1'b0;
`ifdef WB_FAST_EN
    if (win_valid) begin
      take      = 1'b1;
      state_d   = WRITE;
      regw_d    = (win_dest != 5'd0);
      ack_d[win_idx] = 1'b1;
    end else begin
      state_d = IDLE;
    end
`else
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          take    = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: begin
        state_d       = WRITE;
        regw_d        = (wreg_q != 5'd0);
        ack_d[sel_q]  = 1'b1;
      end
      WRITE: begin
        if (win_valid) begin
          take    = 1'b1;
          state_d = SELECT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`endif
    if (take) begin
      sel_d  = win_idx;
      wreg_d = win_dest;
      if (win_idx != SEL_W'(EXC_SRC)) rr_d = rr_after(win_idx);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      wreg_q  <= '0;
      regw_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      wreg_q  <= wreg_d;
      regw_q  <= regw_d;
      ack_q   <= ack_d;
    end
  end

  assign ack        = ack_q;
  assign mem_to_reg = sel_q;
  assign reg_write  = regw_q;
  assign write_reg  = wreg_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_wb_arbiter_ctrl.sv
// Directed self-checking bench for wb_arbiter_ctrl; inputs and samples change on the falling edge.
module tb_wb_arbiter_ctrl;

  localparam int N_SRC = 9;

  logic               clk;
  logic               reset;
  logic [N_SRC-1:0]   req;
  logic [5*N_SRC-1:0] dest_flat;
  logic [N_SRC-1:0]   ack;
  logic [3:0]         mem_to_reg;
  logic               reg_write;
  logic [4:0]         write_reg;
  logic               busy;

  int   checks = 0;
  int   errors = 0;
  logic auto_drop = 1'b1;

  wb_arbiter_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .dest_flat  (dest_flat),
    .ack        (ack),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_dest(input int i, input logic [4:0] d);
    dest_flat[5*i +: 5] = d;
  endtask

  // A well-behaved source drops its request once it sees its ack.
  task automatic step();
    @(negedge clk);
    if (auto_drop) req = req & ~ack;
  endtask

  function automatic logic [N_SRC-1:0] onehot(input int i);
    logic [N_SRC-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_ack"},  32'(ack), 0);
    check({tag, "_m2r"},  32'(mem_to_reg), 0);
    check({tag, "_rw"},   32'(reg_write), 0);
    check({tag, "_wreg"}, 32'(write_reg), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

`ifndef WB_FAST_EN
  int all_order [8] = '{0, 1, 2, 3, 4, 6, 7, 8};
  int rr_order  [4] = '{0, 3, 7, 0};
`endif

  initial begin
    reset = 1'b0;
    req   = '1;
    dest_flat = '0;
    for (int i = 0; i < N_SRC; i++) set_dest(i, 5'(i + 8));

    repeat (3) step();
    check_idle_zero("rst_hold");

`ifndef WB_FAST_EN
    // All sources at once: exception first, then round-robin from 0.
    reset = 1'b1;
    step();
    check("first_m2r", 32'(mem_to_reg), 5);
    check("first_wreg", 32'(write_reg), 31);
    check("first_rw", 32'(reg_write), 0);
    check("first_busy", 32'(busy), 1);
    step();
    check("first_ack", 32'(ack), 32'(onehot(5)));
    check("first_rw_w", 32'(reg_write), 1);
    for (int g = 0; g < 8; g++) begin
      step();
      check("all_sel_m2r", 32'(mem_to_reg), 32'(all_order[g]));
      check("all_sel_ack", 32'(ack), 0);
      step();
      check("all_wr_ack", 32'(ack), 32'(onehot(all_order[g])));
      check("all_wr_wreg", 32'(write_reg), 32'(all_order[g] + 8));
    end
    step();
    check("all_done_busy", 32'(busy), 0);
    check("all_done_rw", 32'(reg_write), 0);

    // Single request, dest change after grant must be ignored.
    set_dest(3, 5'd8);
    req = 9'h008;
    step();
    check("single_m2r", 32'(mem_to_reg), 3);
    check("single_wreg", 32'(write_reg), 8);
    check("single_rw0", 32'(reg_write), 0);
    set_dest(3, 5'd20);
    step();
    check("single_rw1", 32'(reg_write), 1);
    check("single_ack", 32'(ack), 32'h008);
    check("single_wreg_hold", 32'(write_reg), 8);
    step();
    check("single_idle_busy", 32'(busy), 0);
    check("single_idle_rw", 32'(reg_write), 0);
    check("single_idle_m2r", 32'(mem_to_reg), 3);

    // Round-robin with held requests from a fresh pointer.
    reset = 1'b0;
    step();
    reset = 1'b1;
    auto_drop = 1'b0;
    req = 9'h089;
    for (int g = 0; g < 4; g++) begin
      step();
      check("rr_m2r", 32'(mem_to_reg), 32'(rr_order[g]));
      check("rr_sel_rw", 32'(reg_write), 0);
      step();
      check("rr_ack", 32'(ack), 32'(onehot(rr_order[g])));
    end
    req = '0;
    auto_drop = 1'b1;
    step();
    check("rr_done_busy", 32'(busy), 0);

    // Destination zero: ack pulses, no write.
    set_dest(1, 5'd0);
    req = 9'h002;
    step();
    check("zero_m2r", 32'(mem_to_reg), 1);
    check("zero_sel_rw", 32'(reg_write), 0);
    step();
    check("zero_ack", 32'(ack), 32'h002);
    check("zero_wr_rw", 32'(reg_write), 0);
    step();
    check("zero_idle_busy", 32'(busy), 0);

    // Abort during SELECT, then completion after release.
    req = 9'h010;
    step();
    check("abort_sel_m2r", 32'(mem_to_reg), 4);
    reset = 1'b0;
    #1;
    check_idle_zero("abort_now");
    step();
    check_idle_zero("abort_held");
    reset = 1'b1;
    step();
    check("abort_re_m2r", 32'(mem_to_reg), 4);
    check("abort_re_wreg", 32'(write_reg), 12);
    step();
    check("abort_re_ack", 32'(ack), 32'h010);
    check("abort_re_rw", 32'(reg_write), 1);
    step();
    check("abort_re_busy", 32'(busy), 0);
`else
    // Fast path: grant lands directly in WRITE, back-to-back writes.
    req = 9'h041;
    reset = 1'b1;
    auto_drop = 1'b0;
    step();
    check("fast_m2r0", 32'(mem_to_reg), 0);
    check("fast_rw0", 32'(reg_write), 1);
    check("fast_ack0", 32'(ack), 32'h001);
    check("fast_wreg0", 32'(write_reg), 8);
    step();
    check("fast_m2r1", 32'(mem_to_reg), 6);
    check("fast_rw1", 32'(reg_write), 1);
    check("fast_ack1", 32'(ack), 32'h040);
    check("fast_wreg1", 32'(write_reg), 14);
    req = '0;
    step();
    check("fast_idle_busy", 32'(busy), 0);
    check("fast_idle_rw", 32'(reg_write), 0);
    check("fast_idle_m2r", 32'(mem_to_reg), 6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
